// File: rtl/bakraid_sndcomm_68k.sv
// ---------------------------------------------------------------------------
// bakraid_sndcomm_68k
//
// Main-CPU (68000) side of the sound-board mailbox. A 4-word window lets the
// 68k write two command latches toward the Z80 and read back two reply
// latches plus a status byte. Each latch write fires a SND_CS pulse, which
// sets the sound-side WAIT flip-flop. A write to latch 2 also fires SND_NMI.
// Reads of the reply latches are held off (DTACK stretched) while the Z80
// still owes a reply. The Z80's SNDIRQ is edge-detected into a sticky 68k
// interrupt.
//
// Register map (CPU_ADDR):
//   write 0 : SOUNDLATCH  <= data, SND_CS pulse
//   write 1 : SOUNDLATCH2 <= data, SND_CS + SND_NMI pulse
//   write 2 : no effect
//   write 3 : clear pending interrupt (and the timeout flag, if built in)
//   read  0 : SOUNDLATCH3
//   read  1 : SOUNDLATCH4
//   read  2 : {5'b0, tmo, irq_pend, SND_WAIT}
//   read  3 : 8'hFF
//
// Ports:
//   CLK96        sole clock
//   RESET96      synchronous active-high reset
//   CPU_CS       decoded 68k strobe, held until DTACK seen
//   CPU_RNW      1 = read, 0 = write
//   CPU_ADDR     word offset in window
//   CPU_DIN      write data (low byte)
//   CPU_DOUT     read data, valid while CPU_DTACK_N = 0
//   CPU_DTACK_N  bus acknowledge, active low
//   CPU_IRQ      level interrupt to the 68k
//   SOUNDLATCH   latch 1 to the Z80
//   SOUNDLATCH2  latch 2 to the Z80
//   SND_CS       pulse, rising edge sets the sound-side WAIT
//   SND_NMI      pulse, rising edge interrupts the Z80
//   SOUNDLATCH3  Z80 reply latch 3
//   SOUNDLATCH4  Z80 reply latch 4
//   SND_WAIT     1 while the Z80 has not yet replied
//   SNDIRQ       Z80 interrupt request toward the 68k
//
// Parameters:
//   PULSE_LEN    width of SND_CS / SND_NMI in clocks (>= 2)
//   TIMEOUT_CYC  stall limit in clocks (timeout build only)
//
// Build option:
//   SNDCOMM_TIMEOUT_EN  when defined, a stalled access is forced through
//                       after TIMEOUT_CYC stall cycles and the sticky tmo
//                       status bit is set. When undefined, a stall lasts
//                       until the stall condition clears.
// ---------------------------------------------------------------------------
module bakraid_sndcomm_68k #(
    parameter int PULSE_LEN   = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic       CLK96,
    input  logic       RESET96,
    input  logic       CPU_CS,
    input  logic       CPU_RNW,
    input  logic [1:0] CPU_ADDR,
    input  logic [7:0] CPU_DIN,
    output logic [7:0] CPU_DOUT,
    output logic       CPU_DTACK_N,
    output logic       CPU_IRQ,
    output logic [7:0] SOUNDLATCH,
    output logic [7:0] SOUNDLATCH2,
    output logic       SND_CS,
    output logic       SND_NMI,
    input  logic [7:0] SOUNDLATCH3,
    input  logic [7:0] SOUNDLATCH4,
    input  logic       SND_WAIT,
    input  logic       SNDIRQ
);

    localparam int             PCW        = $clog2(PULSE_LEN + 1);
    localparam logic [PCW-1:0] PULSE_LOAD = PCW'(PULSE_LEN);

    // Elaboration-time guard on parameter ranges.
    if (PULSE_LEN < 2 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("bakraid_sndcomm_68k: PULSE_LEN must be >= 2 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_STALL,
        ST_ACK
    } state_t;

    state_t         state_q, state_d;

    // Access captured while in DECODE, replayed from these while stalled.
    logic           cmd_rnw_q;
    logic [1:0]     cmd_addr_q;
    logic [7:0]     cmd_din_q;

    logic [PCW-1:0] pcnt_q, pcnt_d;
    logic           nmi_q, nmi_d;
    logic [7:0]     sl1_q, sl1_d;
    logic [7:0]     sl2_q, sl2_d;
    logic [7:0]     dout_q, dout_d;
    logic           dtack_n_q, dtack_n_d;
    logic           irq_pend_q, irq_pend_d;
    logic           sndirq_q;

    logic           cur_rnw;
    logic [1:0]     cur_addr;
    logic [7:0]     cur_din;
    logic           pulse_busy;
    logic           busy;
    logic           stall_cond;
    logic           force_acc;
    logic           in_access;
    logic           do_access;
    logic           wr_strobe;
    logic           rd_strobe;
    logic           sndirq_rise;
    logic           tmo_flag;

    // In DECODE the live bus is used; once stalled, the captured copy is
    // used so that later bus changes cannot alter the pending access.
    always_comb begin
        if (state_q == ST_DECODE) begin
            cur_rnw  = CPU_RNW;
            cur_addr = CPU_ADDR;
            cur_din  = CPU_DIN;
        end else begin
            cur_rnw  = cmd_rnw_q;
            cur_addr = cmd_addr_q;
            cur_din  = cmd_din_q;
        end
    end

    assign pulse_busy = (pcnt_q != '0);
    // SND_WAIT lags the SND_CS edge by a cycle or two; including the pulse
    // counter keeps a read right after a write from slipping into that gap.
    assign busy       = SND_WAIT | pulse_busy;

    // Latch writes wait for the previous pulse to finish so every write gets
    // its own distinct SND_CS edge; reply reads wait for the Z80.
    assign stall_cond = ~cur_addr[1] & (cur_rnw ? busy : pulse_busy);

    assign in_access  = (state_q == ST_DECODE) || (state_q == ST_STALL);
    assign do_access  = in_access & (~stall_cond | force_acc);
    assign wr_strobe  = do_access & ~cur_rnw;
    assign rd_strobe  = do_access &  cur_rnw;

    assign sndirq_rise = SNDIRQ & ~sndirq_q;

`ifdef SNDCOMM_TIMEOUT_EN
    localparam int TCW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TCW-1:0] stall_cnt_q, stall_cnt_d;
    logic           tmo_q, tmo_d;

    // stall_cnt_q holds the number of STALL cycles already spent, so the
    // TIMEOUT_CYC-th stall cycle is the one that forces the access.
    assign force_acc = (state_q == ST_STALL) &&
                       (stall_cnt_q == TCW'(TIMEOUT_CYC - 1));
    assign tmo_flag  = tmo_q;

    always_comb begin
        stall_cnt_d = '0;
        if (state_q == ST_STALL) begin
            stall_cnt_d = stall_cnt_q + TCW'(1);
        end
        tmo_d = tmo_q;
        if (wr_strobe && cur_addr == 2'd3) begin
            tmo_d = 1'b0;
        end
        if (force_acc && stall_cond) begin
            tmo_d = 1'b1;
        end
    end

    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            stall_cnt_q <= '0;
            tmo_q       <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            tmo_q       <= tmo_d;
        end
    end
`else
    assign force_acc = 1'b0;
    assign tmo_flag  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Access sequencing
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        dtack_n_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (CPU_CS) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE,
            ST_STALL: begin
                state_d = do_access ? ST_ACK : ST_STALL;
            end
            ST_ACK: begin
                // DTACK follows ACK by one clock so CPU_DOUT (registered on
                // the access cycle) is already stable when it asserts.
                if (CPU_CS) begin
                    dtack_n_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Latches, pulse generator, read data and interrupt
    // ------------------------------------------------------------------
    always_comb begin
        sl1_d      = sl1_q;
        sl2_d      = sl2_q;
        dout_d     = dout_q;
        pcnt_d     = pcnt_q;
        nmi_d      = nmi_q;
        irq_pend_d = irq_pend_q;

        if (pulse_busy) begin
            pcnt_d = pcnt_q - PCW'(1);
        end

        if (wr_strobe) begin
            case (cur_addr)
                2'd0: begin
                    sl1_d  = cur_din;
                    pcnt_d = PULSE_LOAD;
                    nmi_d  = 1'b0;
                end
                2'd1: begin
                    sl2_d  = cur_din;
                    pcnt_d = PULSE_LOAD;
                    nmi_d  = 1'b1;
                end
                2'd3: begin
                    irq_pend_d = 1'b0;
                end
                default: begin
                end
            endcase
        end

        if (rd_strobe) begin
            case (cur_addr)
                2'd0:    dout_d = SOUNDLATCH3;
                2'd1:    dout_d = SOUNDLATCH4;
                2'd2:    dout_d = {5'b0, tmo_flag, irq_pend_q, SND_WAIT};
                default: dout_d = 8'hFF;
            endcase
        end

        // A new SNDIRQ edge beats a simultaneous clear.
        if (sndirq_rise) begin
            irq_pend_d = 1'b1;
        end
    end

    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            state_q    <= ST_IDLE;
            cmd_rnw_q  <= 1'b0;
            cmd_addr_q <= 2'd0;
            cmd_din_q  <= 8'h00;
            pcnt_q     <= '0;
            nmi_q      <= 1'b0;
            sl1_q      <= 8'h00;
            sl2_q      <= 8'h00;
            dout_q     <= 8'hFF;
            dtack_n_q  <= 1'b1;
            irq_pend_q <= 1'b0;
            sndirq_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            if (state_q == ST_DECODE) begin
                cmd_rnw_q  <= CPU_RNW;
                cmd_addr_q <= CPU_ADDR;
                cmd_din_q  <= CPU_DIN;
            end
            pcnt_q     <= pcnt_d;
            nmi_q      <= nmi_d;
            sl1_q      <= sl1_d;
            sl2_q      <= sl2_d;
            dout_q     <= dout_d;
            dtack_n_q  <= dtack_n_d;
            irq_pend_q <= irq_pend_d;
            sndirq_q   <= SNDIRQ;
        end
    end

    assign CPU_DOUT    = dout_q;
    assign CPU_DTACK_N = dtack_n_q;
    assign CPU_IRQ     = irq_pend_q;
    assign SOUNDLATCH  = sl1_q;
    assign SOUNDLATCH2 = sl2_q;
    assign SND_CS      = pulse_busy;
    assign SND_NMI     = pulse_busy & nmi_q;

endmodule
